// File: rtl/id_regfile_mp.sv
// id_regfile_mp: multi-port integer register file for the ID stage with a
// pending-write scoreboard used by hazard logic to stall on busy operands.
// Ports: clk_i/rst_ni (sync, active-low reset); rd_addr_i/rd_data_o/rd_busy_o
// are NUM_RD_PORTS flattened read ports; we_i/w_addr_i/w_data_i are
// NUM_WR_PORTS flattened write-back ports; issue_valid_i/issue_addr_i mark a
// destination as pending; flush_i clears every pending bit; any_busy_o is the
// OR of all pending bits. x0 has no storage, reads as zero and is never busy.
// Optional macro PRIMUS_RF_BYPASS_EN forwards same-cycle write data to reads.
module id_regfile_mp #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int AW           = $clog2(NUM_REGS)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD_PORTS-1:0]            rd_busy_o,
    input  logic [NUM_WR_PORTS-1:0]            we_i,
    input  logic [NUM_WR_PORTS*AW-1:0]         w_addr_i,
    input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] w_data_i,
    input  logic                               issue_valid_i,
    input  logic [AW-1:0]                      issue_addr_i,
    input  logic                               flush_i,
    output logic                               any_busy_o
);

    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   pend_q;
    logic [NUM_REGS-1:1]   pend_d;

    // Loops start at 1, so address 0 never matches: x0 writes and issues
    // fall away without any extra guard. Later write ports overwrite earlier
    // ones, a same-cycle issue overrides the write-back clear, and flush
    // overrides everything on the scoreboard.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (we_i[k] && w_addr_i[k*AW +: AW] == AW'(r)) begin
                    regs_d[r] = w_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    pend_d[r] = 1'b0;
                end
            end
            if (issue_valid_i && issue_addr_i == AW'(r)) begin
                pend_d[r] = 1'b1;
            end
        end
        if (flush_i) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (rd_addr_i[p*AW +: AW] == AW'(r)) begin
                    rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
                    rd_busy_o[p] = pend_q[r];
                end
            end
`ifdef PRIMUS_RF_BYPASS_EN
            // Forwarded data is no longer pending unless a new producer
            // claims the same register in this very cycle.
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (we_i[k] && w_addr_i[k*AW +: AW] != '0 &&
                    w_addr_i[k*AW +: AW] == rd_addr_i[p*AW +: AW]) begin
                    rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] =
                        w_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    rd_busy_o[p] = issue_valid_i &&
                                   issue_addr_i == rd_addr_i[p*AW +: AW];
                end
            end
`endif
        end
    end

    assign any_busy_o = |pend_q;

endmodule

// File: doc/id_regfile_mp.md
Name: id_regfile_mp

Overview:
- Parametrised multi-port integer register file for the ID stage, with an integrated pending-write scoreboard.
- Supports NUM_RD_PORTS combinational read ports, NUM_WR_PORTS write-back ports and RV32I/RV32E register counts.
- Tracks registers with an in-flight write so hazard logic can stall on busy operands.
- Register x0 is hardwired to zero and is never pending.

Parameters:
- DATA_WIDTH, 64, width of each register.
- NUM_REGS, 32, architectural register count; legal values 32 (RV32I) or 16 (RV32E).
- NUM_RD_PORTS, 2, number of read ports; legal range 1..4.
- NUM_WR_PORTS, 1, number of write-back ports; legal range 1..2.
- AW, $clog2(NUM_REGS), register address width; derived, do not override.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- rd_addr_i  input  NUM_RD_PORTS*AW  read addresses, flattened; port p at [p*AW +: AW].
- rd_data_o  output  NUM_RD_PORTS*DATA_WIDTH  read data, flattened.
- rd_busy_o  output  NUM_RD_PORTS  pending bit of the addressed register.
- we_i  input  NUM_WR_PORTS  write enable per write port.
- w_addr_i  input  NUM_WR_PORTS*AW  write addresses.
- w_data_i  input  NUM_WR_PORTS*DATA_WIDTH  write data.
- issue_valid_i  input  1  an instruction with destination issue_addr_i issues this cycle.
- issue_addr_i  input  AW  destination register of the issuing instruction.
- flush_i  input  1  clear all pending bits (pipeline flush).
- any_busy_o  output  1  OR of all pending bits.

Behaviour:
- State:
  - regs[1..NUM_REGS-1], each DATA_WIDTH wide.
  - pend[1..NUM_REGS-1], 1 bit each.
  - No storage for x0.
- Reset (rst_ni=0 at a rising edge):
  - All regs and all pend bits go to 0.
  - After that edge, every rd_data_o port = 0, every rd_busy_o bit = 0, any_busy_o = 0.
  - Reset has priority over all write, issue and flush activity in the same cycle.
- Reads:
  - Combinational, zero latency, from the registered state.
  - Address 0 returns 0 with busy = 0.
  - Ports are fully independent; identical addresses on several ports are legal.
- Writes:
  - Performed at the rising edge when we_i[k]=1 and w_addr_i[k]!=0.
  - Writes to x0 are discarded.
  - Two write ports targeting the same address in one cycle: the higher port index wins.
- Scoreboard update order within one edge:
  1. Clear: for each active write port k with w_addr_i[k]!=0, pend[w_addr_i[k]] <= 0.
  2. Set: if issue_valid_i=1 and issue_addr_i!=0, pend[issue_addr_i] <= 1. Set overrides a same-cycle clear of the same register, because the new producer supersedes the old one.
  3. Flush: if flush_i=1, all pend <= 0. Flush overrides set and clear, and register writes still occur normally.
- issue_valid_i with issue_addr_i=0 has no effect.
- Issuing to a register that is already pending is legal; it stays pending until the next write-back to that register.
- any_busy_o is combinational from the registered pend bits.
- Write-after-write hazards are outside this block's scope: the scoreboard keeps a single bit per register, not a count.

Optional Feature:
- Macro: PRIMUS_RF_BYPASS_EN.
- Defined: each read port whose address matches an active write port (we_i=1, non-zero address) in the current cycle returns that port's w_data_i. If several write ports match, the highest index wins. rd_busy_o for that port reads 0 unless issue_valid_i targets the same address in the same cycle. Reads remain purely combinational.
- Not defined: reads return registered contents only, so written data is visible from the cycle after the write edge. rd_busy_o reflects registered pend bits only.

Test Plan:
- Reset, then read all addresses on every port -> rd_data_o=0 on every port, rd_busy_o=0, any_busy_o=0.
- Write 0xDEAD_BEEF_0000_0001 to x5, then read x5 on ports 0 and 1 next cycle -> both return 0xDEAD_BEEF_0000_0001. Write 0x1234 to x0, then read x0 -> 0.
- With NUM_WR_PORTS=2, write x7 with 0xAA on port 0 and 0xBB on port 1 in the same cycle -> x7 reads 0xBB.
- Scoreboard sequence:
  - issue x9 -> rd_busy_o=1 for x9 and any_busy_o=1 in the following cycle.
  - write-back x9 -> busy drops the next cycle.
  - issue x9 and write-back x9 in the same cycle -> x9 remains busy.
  - issue x3 and assert flush_i in the same cycle -> no register is pending.
- Bypass: read x4 while writing 0x55 to x4, where x4 previously held 0x11 -> returns 0x55 with PRIMUS_RF_BYPASS_EN defined, 0x11 without it; both builds return 0x55 in the next cycle.
- Reset mid-operation: x10 holds 0x99 and x10 is pending; assert rst_ni=0 together with a write of 0x77 to x10 -> after the edge x10 reads 0 and is not busy. NUM_REGS=16 build: write x15 -> reads back correctly.
